// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial bit-pattern transmitter. Latches a pattern of up to MAX_LEN bits and
//   shifts its active field pattern[len-1:0] out MSB first, one bit per clock.
//   Frames can be repeated (repeat_n, 0 behaves as 1) with an optional idle gap
//   of gap cycles between frames (never after the last one).
//
// Ports
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high reset
//   start    : single-cycle request, sampled only in IDLE
//   pattern  : bits to send, active field pattern[len-1:0]
//   len      : bits per frame (0 = request ignored, > MAX_LEN clamped)
//   repeat_n : frames to send (0 treated as 1)
//   gap      : idle cycles between frames
//   out      : serial data bit (0 outside SEND)
//   valid    : out carries a pattern bit
//   busy     : high from the first bit through the done cycle
//   done     : one-cycle pulse after the last bit of the last frame
//
// All outputs are registers whose values are computed from the next state,
// so they change only on clock edges and never follow the inputs directly.
module seq_pattern_tx #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic [CNT_W-1:0]   repeat_n,
   input  logic [CNT_W-1:0]   gap,
   output logic               out,
   output logic               valid,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   frames_q, frames_d;
   logic [CNT_W-1:0]   gap_q, gap_d;
   logic [CNT_W-1:0]   gcnt_q, gcnt_d;
   logic               out_d, valid_d, busy_d, done_d;
   logic [LEN_W-1:0]   len_eff;

   // Select bit i of p; a shift keeps out-of-range indices well defined.
   function automatic logic bit_at(input logic [MAX_LEN-1:0] p,
                                   input logic [LEN_W-1:0]   i);
      logic [MAX_LEN-1:0] s;
      s = p >> i;
      return s[0];
   endfunction

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      len_d    = len_q;
      idx_d    = idx_q;
      frames_d = frames_q;
      gap_d    = gap_q;
      gcnt_d   = gcnt_q;
      out_d    = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      len_eff  = (len > MAX_LEN_L) ? MAX_LEN_L : len;

      case (state_q)
         IDLE: begin
            if (start && (len != '0)) begin
               pat_d    = pattern;
               len_d    = len_eff;
               frames_d = (repeat_n == '0) ? CNT_ONE : repeat_n;
               gap_d    = gap;
               idx_d    = len_eff - LEN_ONE;
               state_d  = SEND;
               out_d    = bit_at(pattern, len_eff - LEN_ONE);
               valid_d  = 1'b1;
               busy_d   = 1'b1;
            end
         end

         SEND: begin
            busy_d = 1'b1;
            if (idx_q != '0) begin
               idx_d   = idx_q - LEN_ONE;
               out_d   = bit_at(pat_q, idx_q - LEN_ONE);
               valid_d = 1'b1;
            end else if (frames_q > CNT_ONE) begin
               // Bit 0 of a non-final frame: either idle for gap cycles or
               // restart the frame back-to-back with no bubble.
               frames_d = frames_q - CNT_ONE;
               if (gap_q != '0) begin
                  state_d = GAP;
                  gcnt_d  = gap_q;
               end else begin
                  idx_d   = len_q - LEN_ONE;
                  out_d   = bit_at(pat_q, len_q - LEN_ONE);
                  valid_d = 1'b1;
               end
            end else begin
               frames_d = '0;
               state_d  = DONE;
               done_d   = 1'b1;
            end
         end

         GAP: begin
            busy_d = 1'b1;
            // gcnt counts the gap cycles still to be shown, including this one.
            if (gcnt_q == CNT_ONE) begin
               gcnt_d  = '0;
               state_d = SEND;
               idx_d   = len_q - LEN_ONE;
               out_d   = bit_at(pat_q, len_q - LEN_ONE);
               valid_d = 1'b1;
            end else begin
               gcnt_d = gcnt_q - CNT_ONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         pat_q    <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         frames_q <= '0;
         gap_q    <= '0;
         gcnt_q   <= '0;
         out      <= 1'b0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         frames_q <= frames_d;
         gap_q    <= gap_d;
         gcnt_q   <= gcnt_d;
         out      <= out_d;
         valid    <= valid_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx. Each vector holds the inputs present at one
// rising edge and the {out,valid,busy,done} expected just after that edge.
module tb_seq_pattern_tx;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   len;
   logic [CNT_W-1:0]   repeat_n;
   logic [CNT_W-1:0]   gap;
   logic               out, valid, busy, done;

   int n_vec  = 0;
   int n_fail = 0;

   seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pattern  (pattern),
      .len      (len),
      .repeat_n (repeat_n),
      .gap      (gap),
      .out      (out),
      .valid    (valid),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string              name;
      logic               rst;
      logic               st;
      logic [MAX_LEN-1:0] pat;
      logic [LEN_W-1:0]   ln;
      logic [CNT_W-1:0]   rep;
      logic [CNT_W-1:0]   gp;
      logic [3:0]         exp;   // {out, valid, busy, done}
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic r, input logic s,
                      input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic [CNT_W-1:0] rp, input logic [CNT_W-1:0] g,
                      input logic [3:0] e);
      vec_t v;
      v.name = nm; v.rst = r; v.st = s; v.pat = p; v.ln = l;
      v.rep = rp; v.gp = g; v.exp = e;
      vecs.push_back(v);
   endtask

   // Shorthand for a plain clock with idle inputs.
   task automatic idle(input string nm, input logic [3:0] e);
      add(nm, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, e);
   endtask

   task automatic drive(input logic r, input logic s, input logic [MAX_LEN-1:0] p,
                        input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] rp,
                        input logic [CNT_W-1:0] g);
      reset = r; start = s; pattern = p; len = l; repeat_n = rp; gap = g;
   endtask

   task automatic step_check(input string nm, input logic [3:0] e);
      @(posedge clk);
      #1;
      n_vec++;
      if ({out, valid, busy, done} !== e)
         $display("FAIL %s: {out,valid,busy,done} got %b expected %b", nm,
                  {out, valid, busy, done}, e);
      if ({out, valid, busy, done} !== e) n_fail++;
   endtask

   initial begin
      drive(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0);

      // Reset state
      add("reset", 1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 4'b0000);
      idle("idle", 4'b0000);

      // 101, one frame; inputs scrambled after start to confirm latching
      add("a_b2", 1'b0, 1'b1, 8'h05, 4'd3, 4'd1, 4'd0, 4'b1110);
      add("a_b1", 1'b0, 1'b0, 8'hFF, 4'd7, 4'd5, 4'd3, 4'b0110);
      add("a_b0", 1'b0, 1'b0, 8'h00, 4'd1, 4'd2, 4'd1, 4'b1110);
      idle("a_done", 4'b0011);
      idle("a_idle", 4'b0000);

      // Two frames, no gap: contiguous 101101
      add("b_1", 1'b0, 1'b1, 8'h05, 4'd3, 4'd2, 4'd0, 4'b1110);
      idle("b_2", 4'b0110);
      idle("b_3", 4'b1110);
      idle("b_4", 4'b1110);
      idle("b_5", 4'b0110);
      idle("b_6", 4'b1110);
      idle("b_done", 4'b0011);
      idle("b_idle", 4'b0000);

      // Two frames with a 2-cycle gap
      add("c_1", 1'b0, 1'b1, 8'h05, 4'd3, 4'd2, 4'd2, 4'b1110);
      idle("c_2", 4'b0110);
      idle("c_3", 4'b1110);
      idle("c_gap1", 4'b0010);
      idle("c_gap2", 4'b0010);
      idle("c_4", 4'b1110);
      idle("c_5", 4'b0110);
      idle("c_6", 4'b1110);
      idle("c_done", 4'b0011);
      idle("c_idle", 4'b0000);

      // A5 over all 8 bits, repeat_n=0 behaves as one frame
      add("d_7", 1'b0, 1'b1, 8'hA5, 4'd8, 4'd0, 4'd0, 4'b1110);
      idle("d_6", 4'b0110); idle("d_5", 4'b1110); idle("d_4", 4'b0110);
      idle("d_3", 4'b0110); idle("d_2", 4'b1110); idle("d_1", 4'b0110);
      idle("d_0", 4'b1110);
      idle("d_done", 4'b0011);
      idle("d_idle", 4'b0000);

      // len=12 clamps to 8: identical output
      add("e_7", 1'b0, 1'b1, 8'hA5, 4'd12, 4'd0, 4'd0, 4'b1110);
      idle("e_6", 4'b0110); idle("e_5", 4'b1110); idle("e_4", 4'b0110);
      idle("e_3", 4'b0110); idle("e_2", 4'b1110); idle("e_1", 4'b0110);
      idle("e_0", 4'b1110);
      idle("e_done", 4'b0011);
      idle("e_idle", 4'b0000);

      // start held high through transmission and the DONE cycle: one frame only
      add("f_b2", 1'b0, 1'b1, 8'h05, 4'd3, 4'd1, 4'd0, 4'b1110);
      add("f_b1", 1'b0, 1'b1, 8'h02, 4'd3, 4'd1, 4'd0, 4'b0110);
      add("f_b0", 1'b0, 1'b1, 8'h02, 4'd3, 4'd1, 4'd0, 4'b1110);
      add("f_done", 1'b0, 1'b1, 8'h02, 4'd3, 4'd1, 4'd0, 4'b0011);
      add("f_start_in_done", 1'b0, 1'b1, 8'h02, 4'd3, 4'd1, 4'd0, 4'b0000);
      idle("f_idle", 4'b0000);

      // start with len=0 is ignored
      add("g_len0", 1'b0, 1'b1, 8'hFF, 4'd0, 4'd1, 4'd0, 4'b0000);
      idle("g_idle1", 4'b0000);
      idle("g_idle2", 4'b0000);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].st, vecs[i].pat, vecs[i].ln, vecs[i].rep, vecs[i].gp);
         step_check(vecs[i].name, vecs[i].exp);
      end

      // Reset while bit index 1 is on the line: everything drops, no done pulse
      drive(1'b0, 1'b1, 8'h05, 4'd3, 4'd2, 4'd1);
      step_check("r_b2", 4'b1110);
      drive(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0);
      step_check("r_b1", 4'b0110);
      drive(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0);
      step_check("r_reset", 4'b0000);
      drive(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0);
      step_check("r_no_done", 4'b0000);
      step_check("r_idle", 4'b0000);

      // Fresh frame 110 after the aborted one
      drive(1'b0, 1'b1, 8'h06, 4'd3, 4'd1, 4'd0);
      step_check("s_b2", 4'b1110);
      drive(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0);
      step_check("s_b1", 4'b1110);
      step_check("s_b0", 4'b0110);
      step_check("s_done", 4'b0011);
      step_check("s_idle", 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
